apb_phase_node: RTL

APB_PHASE_NODE -- requirements
Module: apb_phase_node

---
 rtl/apb_phase_node.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/apb_phase_node.sv
// APB phase node: decodes one upstream request onto one of NUM_SLAVES APB ports.
// Optional ACCESS-phase timeout when APB_PHASE_NODE_TIMEOUT_EN is defined.
module apb_phase_node #(
  parameter int          NUM_SLAVES     = 8,
  parameter int          APB_ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h1A10_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     req_valid_i,
  input  logic                     req_write_i,
  input  logic [31:0]              req_addr_i,
  input  logic [31:0]              req_wdata_i,
  output logic                     req_ready_o,
  output logic [31:0]              req_rdata_o,
  output logic                     req_slverr_o,
  output logic [NUM_SLAVES-1:0]    psel_o,
  output logic                     penable_o,
  output logic                     pwrite_o,
  output logic [31:0]              paddr_o,
  output logic [31:0]              pwdata_o,
  input  logic [NUM_SLAVES*32-1:0] prdata_i,
  input  logic [NUM_SLAVES-1:0]    pready_i,
  input  logic [NUM_SLAVES-1:0]    pslverr_i
);

  localparam int IDX_W = $clog2(NUM_SLAVES);
  localparam int HI    = APB_ADDR_WIDTH + IDX_W;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, ERR} state_e;

  state_e            state_q, state_d;
  logic              write_q;
  logic [31:0]       addr_q, wdata_q, rdata_q;
  logic [IDX_W-1:0]  idx_q;
  logic              slverr_q;

  logic              hit;
  logic [IDX_W-1:0]  idx;
  logic              sel_ready, sel_slverr, timeout_hit;
  logic [31:0]       sel_rdata;

  assign hit = (req_addr_i[31:HI] == BASE_ADDR[31:HI]);
  assign idx = req_addr_i[HI-1:APB_ADDR_WIDTH];

  // Only the captured slave's response lines are ever looked at.
  assign sel_ready  = pready_i[idx_q];
  assign sel_slverr = pslverr_i[idx_q];
  assign sel_rdata  = prdata_i[int'(idx_q)*32 +: 32];

`ifdef APB_PHASE_NODE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;

  assign timeout_hit = (state_q == ACCESS) && (cnt_q == TIMEOUT_LAST);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                            cnt_q <= '0;
    else if (state_q == SETUP)               cnt_q <= '0;
    else if (state_q == ACCESS && !sel_ready) cnt_q <= cnt_q + 16'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: defaults first in every combinational block prevent latch inference.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i) state_d = hit ? SETUP : ERR;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (sel_ready || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      idx_q    <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid_i) begin
        write_q <= req_write_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        idx_q   <= idx;
      end
      // A real pready wins over a simultaneous timeout.
      if (state_q == ACCESS) begin
        if (sel_ready) begin
          rdata_q  <= write_q ? 32'h0 : sel_rdata;
          slverr_q <= sel_slverr;
        end else if (timeout_hit) begin
          rdata_q  <= 32'h0;
          slverr_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    psel_o       = '0;
    penable_o    = 1'b0;
    req_ready_o  = 1'b0;
    req_rdata_o  = 32'h0;
    req_slverr_o = 1'b0;
    unique case (state_q)
      SETUP:  psel_o[idx_q] = 1'b1;
      ACCESS: begin
        psel_o[idx_q] = 1'b1;
        penable_o     = 1'b1;
      end
      RESP: begin
        req_ready_o  = 1'b1;
        req_rdata_o  = rdata_q;
        req_slverr_o = slverr_q;
      end
      ERR: begin
        req_ready_o  = 1'b1;
        req_slverr_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign pwrite_o = write_q;
  assign paddr_o  = addr_q;
  assign pwdata_o = wdata_q;

endmodule
